// File: rtl/fltadd_seq.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even.
// Alignment and normalisation shift one bit per cycle; start/busy/done handshake.
module fltadd_seq #(
    parameter  int unsigned EXP_W = 5,
    parameter  int unsigned MAN_W = 10,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         uf
);

    localparam int unsigned MW      = MAN_W + 1;        // mantissa incl. hidden bit
    localparam int unsigned SW      = MW + 3;           // plus guard, round, sticky
    localparam int unsigned AW      = SW + 1;           // plus carry
    localparam int unsigned XW      = EXP_W + 2;        // signed exponent with headroom
    localparam int unsigned KMAX    = MAN_W + 3;
    localparam int unsigned CW      = $clog2(KMAX + 1);
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic                  sign_q, sign_d;
    logic                  sub_q, sub_d;
    logic [MW-1:0]         big_q, big_d;
    logic [SW-1:0]         small_q, small_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [W-1:0]          result_q, result_d;
    logic                  ovf_q, ovf_d;
    logic                  uf_q, uf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Operand decode and magnitude ordering for the accept cycle
    logic [EXP_W-1:0] ea_c, eb_c, d_c;
    logic [MW-1:0]    ma_c, mb_c;
    logic             sb_eff_c, a_big_c;
    logic [CW-1:0]    k_c;

    assign ea_c     = a[W-2 -: EXP_W];
    assign eb_c     = b[W-2 -: EXP_W];
    assign ma_c     = (ea_c != '0) ? {1'b1, a[MAN_W-1:0]} : '0;
    assign mb_c     = (eb_c != '0) ? {1'b1, b[MAN_W-1:0]} : '0;
    assign sb_eff_c = b[W-1] ^ op;
    assign a_big_c  = {ea_c, ma_c} >= {eb_c, mb_c};
    assign d_c      = a_big_c ? (ea_c - eb_c) : (eb_c - ea_c);
    assign k_c      = (32'(d_c) > KMAX) ? CW'(KMAX) : CW'(d_c);

    // Datapath helpers for ADD, NORM and ROUND
    logic [AW-1:0]        sum_c, norm_c;
    logic [MW:0]          rnd_c;
    logic [MW-1:0]        mant_r_c;
    logic signed [XW-1:0] exp_r_c;
    logic                 inc_c, rovf_c, ruf_c, rzero_c;

    assign sum_c = sub_q ? ({1'b0, big_q, 3'b000} - {1'b0, small_q})
                         : ({1'b0, big_q, 3'b000} + {1'b0, small_q});

    assign norm_c = acc_q[AW-1] ? {1'b0, acc_q[AW-1:2], acc_q[1] | acc_q[0]}
                                : {acc_q[AW-2:0], 1'b0};

    assign inc_c    = acc_q[2] & (acc_q[1] | acc_q[0] | acc_q[3]);
    assign rnd_c    = {1'b0, acc_q[AW-2:3]} + (MW+1)'(inc_c);
    assign mant_r_c = rnd_c[MW] ? rnd_c[MW:1] : rnd_c[MW-1:0];
    assign exp_r_c  = rnd_c[MW] ? (exp_q + XW'(1)) : exp_q;
    assign rzero_c  = (mant_r_c == '0);
    assign rovf_c   = exp_r_c > $signed(XW'(EXP_MAX));
    assign ruf_c    = exp_r_c < $signed(XW'(1));

    function automatic logic needs_norm(input logic [AW-1:0] v);
        return v[AW-1] | (~v[AW-2] & (|v));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            big_q    <= '0;
            small_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            uf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            big_q    <= big_d;
            small_q  <= small_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            uf_q     <= uf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        big_d    = big_q;
        small_d  = small_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        uf_d     = uf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    big_d   = a_big_c ? ma_c : mb_c;
                    small_d = {(a_big_c ? mb_c : ma_c), 3'b000};
                    exp_d   = XW'(a_big_c ? ea_c : eb_c);
                    sign_d  = a_big_c ? a[W-1] : sb_eff_c;
                    sub_d   = a[W-1] ^ sb_eff_c;
                    cnt_d   = k_c;
                    busy_d  = 1'b1;
                    state_d = (d_c == '0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                // Bits falling off the bottom collapse into sticky
                small_d = {1'b0, small_q[SW-1:2], small_q[1] | small_q[0]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_ADD;
            end
            S_ADD: begin
                acc_d = sum_c;
                if (sum_c == '0) sign_d = 1'b0;
                state_d = needs_norm(sum_c) ? S_NORM : S_ROUND;
            end
            S_NORM: begin
                acc_d   = norm_c;
                exp_d   = acc_q[AW-1] ? (exp_q + XW'(1)) : (exp_q - XW'(1));
                state_d = needs_norm(norm_c) ? S_NORM : S_ROUND;
            end
            S_ROUND: begin
                if (rzero_c) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    uf_d     = 1'b0;
                end else if (rovf_c) begin
                    result_d = {sign_q, {(W-1){1'b1}}};
                    ovf_d    = 1'b1;
                    uf_d     = 1'b0;
                end else if (ruf_c) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    ovf_d    = 1'b0;
                    uf_d     = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r_c[EXP_W-1:0], mant_r_c[MAN_W-1:0]};
                    ovf_d    = 1'b0;
                    uf_d     = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign uf     = uf_q;

endmodule

// File: tb/tb_fltadd_seq.sv
// Directed bench for fltadd_seq: scoreboard of expected result/flags/latency per operation.
module tb_fltadd_seq;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned W     = 1 + EXP_W + MAN_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, ovf, uf;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    fltadd_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .uf     (uf)
    );

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        uf;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one operation from the current cycle; returns in the done cycle.
    // hold>0 keeps start high (with junk operands) until cycle 'hold'.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic top,
                          input logic [15:0] eres, input logic eovf, input logic euf,
                          input int elat, input int hold);
        exp_t e;
        int   cyc;
        e.res = eres; e.ovf = eovf; e.uf = euf; e.lat = elat;
        sb_q.push_back(e);
        a = ta; b = tbv; op = top; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        if (hold == 0) start = 1'b0;
        else begin a = 16'h7FFF; b = 16'h7FFF; end
        check("busy_after_accept", 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc >= hold) start = 1'b0;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("done_seen", 32'(done), 32'd1);
        check("result", 32'(result), 32'(e.res));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("uf", 32'(uf), 32'(e.uf));
        check("latency", 32'(cyc), 32'(e.lat));
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("done_low", 32'(done), 32'd0);
            check("busy_low", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_uf", 32'(uf), 32'd0);
        reset = 1'b0;
        idle(2);

        run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 4, 0);  idle(2);
        run_op(16'h3C01, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 4, 0);  idle(2);
        run_op(16'h3C03, 16'h3C00, 1'b0, 16'h4002, 1'b0, 1'b0, 4, 0);  idle(2);
        run_op(16'h3C01, 16'h3C00, 1'b1, 16'h1400, 1'b0, 1'b0, 13, 0); idle(2);
        run_op(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0, 3, 0);  idle(2);
        run_op(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 1'b0, 5, 0);  idle(2);
        run_op(16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1, 13, 0); idle(2);
        run_op(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0, 16, 0); idle(2);
        run_op(16'h0000, 16'hBC00, 1'b0, 16'hBC00, 1'b0, 1'b0, 16, 0); idle(2);
        run_op(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, 1'b0, 4, 0);  idle(2);

        // Abort an operation with reset while it is aligning
        a = 16'h7C00; b = 16'h3C00; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_align", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_uf", 32'(uf), 32'd0);
        idle(20);
        run_op(16'h3C00, 16'h3800, 1'b0, 16'h3E00, 1'b0, 1'b0, 4, 0);  idle(2);

        // start held while busy must not start a second operation
        run_op(16'h3C01, 16'h3C00, 1'b1, 16'h1400, 1'b0, 1'b0, 13, 5);
        idle(20);

        // Back-to-back: second start issued in the done cycle of the first
        run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 4, 0);
        run_op(16'h3C00, 16'h3800, 1'b0, 16'h3E00, 1'b0, 1'b0, 4, 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fltadd_seq.md
Name: fltadd_seq

Overview:
- Parametrised, multi-cycle floating-point add/subtract unit for the CPU's float datapath.
- Successor to the single-shot float+float model. Adds:
  - generic exponent and mantissa widths
  - full net subtraction, including cancellation normalisation
  - round-to-nearest-even
  - a start/busy/done handshake
- Shifts are bit-serial: one bit per cycle.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa width; the hidden bit is implied.
- W, 1+EXP_W+MAN_W, derived total word width; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = a+b, 1 = a-b (b sign inverted)
- a  in  W  operand A {sign, exp, man}
- b  in  W  operand B
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; result is valid from this cycle on
- result  out  W  sum/difference; held until the next accept
- ovf  out  1  result saturated; valid with done, held
- uf  out  1  result flushed to zero; valid with done, held

Behaviour:
- Format:
  - exp==0 means zero (mantissa ignored). No denormals, no inf/NaN.
  - exp==2^EXP_W-1 is an ordinary normal exponent.
- Reset (synchronous, active-high; clock clk):
  - state=IDLE; busy=0, done=0, result=0, ovf=0, uf=0.
  - Reset mid-operation aborts with no done pulse.
- IDLE:
  - start=1 captures a, b and op, computes d=|ea-eb|, and goes to ALIGN (or ADD if d=0). This is cycle 0.
  - start while busy is ignored.
- Internal datapath:
  - Mantissas are MAN_W+1 bits including hidden bit (hidden = exp!=0).
  - Plus guard, round and sticky bits, plus 1 carry bit.
  - The operand with the larger magnitude (exp, then mantissa) is "big"; its exponent is the provisional result exponent.
- ALIGN:
  - Right-shifts the small mantissa 1 bit/cycle through G->R->sticky (sticky ORs everything lost).
  - Runs k=min(d, MAN_W+3) cycles; beyond that, only sticky changes.
  - A zero operand contributes mantissa 0.
- ADD (1 cycle):
  - Effective signs equal: big + small.
  - Otherwise: big - small, full width including GRS.
  - Result sign = sign of big. Exact zero gives +0.
- NORM, n cycles (n=0 skips the state):
  - On carry-out: one right shift, exp+1, shifted bit into G/R/S.
  - Else while hidden bit is 0: left shift 1/cycle (G shifts in, then zeros), exp-1.
  - Stops when the hidden bit is 1 or the mantissa is zero.
- ROUND (1 cycle):
  - RNE: increment if G & (R | S | lsb).
  - Round carry-out: mantissa>>1, exp+1 in the same cycle.
- Output (registered at the end of ROUND):
  - exp > 2^EXP_W-1 gives result = {sign, all ones, all ones}, ovf=1.
  - exp < 1 with nonzero mantissa gives result = {sign, 0, 0}, uf=1.
  - Zero mantissa gives result = 0, ovf=0, uf=0.
  - done=1 for exactly 1 cycle in cycle k+n+3, then IDLE.
  - A start in the done cycle is accepted.
- Latency = k+n+3 cycles from accept to done. busy falls in the done cycle.

Test Plan (EXP_W=5, MAN_W=10, hex):
- Carry normalisation: a=3C00, b=3C00, op=0 -> result=4000, k=0, n=1, done at cycle 4, ovf=uf=0.
- RNE tie to even: a=3C01, b=3C00, op=0 -> result=4000 (tie to even). a=3C03, b=3C00 -> result=4002 (tie rounds up).
- Cancellation: a=3C01, b=3C00, op=1 -> result=1400, n=10, done at cycle 13. a=3C00, b=3C00, op=1 -> result=0000.
- Saturation: a=7FFF, b=7FFF, op=0 -> result=7FFF, ovf=1. Underflow: a=0401, b=0400, op=1 -> result=0000, uf=1.
- Long alignment: a=7C00, b=3C00, op=0 -> d=16, k=13 -> result=7C00, done at cycle 16. a=0000, b=BC00, op=0 -> result=BC00.
- Handshake: start held during busy is ignored. Reset asserted in ALIGN -> no done, outputs 0; next start completes normally. Back-to-back start in the done cycle is accepted.
